// File: rtl/uart_rx_word_packer.sv
// UART 8N1 receiver that packs four bytes little-endian into a 32-bit word with a one-cycle valid strobe.
// Define UART_RX_WORD_PARITY_EN to expect an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart_rx_word_packer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        div_clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [1:0]  byte_cnt,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        parity_err
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_LIMIT + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_TERM = TW'(TO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_WORD_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_sync;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_lane0, r_lane1, r_lane2;
  logic [TW-1:0]   r_tcnt;
  logic [1:0]      r_byte_cnt;
  logic [31:0]     r_word_out;
  logic            r_word_valid, r_frame_err, r_timeout_err;

  logic w_rx_s, w_half, w_full;
  logic w_start, w_cnt_clr, w_shift_en, w_accept, w_frame_bad, w_timeout;

  assign w_rx_s = r_sync[1];
  assign w_half = (r_clk_cnt == HALF_M1);
  assign w_full = (r_clk_cnt == FULL_M1);

`ifdef UART_RX_WORD_PARITY_EN
  logic r_par_bad, r_parity_err, w_par_smp, w_par_fail;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge div_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_accept     = 1'b0;
    w_frame_bad  = 1'b0;
    w_timeout    = 1'b0;
`ifdef UART_RX_WORD_PARITY_EN
    w_par_smp    = 1'b0;
    w_par_fail   = 1'b0;
`endif
    case (r_state)
      // A start edge on the terminal-count cycle pre-empts the timeout.
      S_IDLE: begin
        if (!w_rx_s) begin
          w_start      = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = S_START;
        end else if (r_byte_cnt != 2'd0 && r_tcnt == TO_TERM) begin
          w_timeout = 1'b1;
        end
      end
      S_START: begin
        if (w_half) begin
          w_cnt_clr    = 1'b1;
          w_next_state = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_WORD_PARITY_EN
            w_next_state = S_PARITY;
`else
            w_next_state = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_WORD_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_cnt_clr    = 1'b1;
          w_par_smp    = 1'b1;
          w_next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_cnt_clr = 1'b1;
          if (!w_rx_s) begin
            w_frame_bad  = 1'b1;
            w_next_state = S_BREAK;
          end else begin
            w_next_state = S_IDLE;
`ifdef UART_RX_WORD_PARITY_EN
            if (r_par_bad) w_par_fail = 1'b1;
            else           w_accept   = 1'b1;
`else
            w_accept = 1'b1;
`endif
          end
        end
      end
      S_BREAK: begin
        if (w_rx_s) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (reset) begin
      r_sync        <= 2'b11;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'd0;
      r_lane0       <= 8'd0;
      r_lane1       <= 8'd0;
      r_lane2       <= 8'd0;
      r_tcnt        <= '0;
      r_byte_cnt    <= 2'd0;
      r_word_out    <= 32'd0;
      r_word_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_sync        <= {r_sync[0], rx};
      r_word_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_clk_cnt     <= w_cnt_clr ? '0 : r_clk_cnt + 1'b1;

      if (w_start) r_bit_cnt <= 3'd0;
      if (w_shift_en) begin
        r_shift   <= {w_rx_s, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state == S_IDLE && r_byte_cnt != 2'd0 && !w_start && !w_timeout)
        r_tcnt <= r_tcnt + 1'b1;
      else
        r_tcnt <= '0;

      if (w_timeout) begin
        r_byte_cnt    <= 2'd0;
        r_timeout_err <= 1'b1;
      end

      // Lane 3 never needs storage: it goes straight into word_out.
      if (w_accept) begin
        case (r_byte_cnt)
          2'd0: r_lane0 <= r_shift;
          2'd1: r_lane1 <= r_shift;
          2'd2: r_lane2 <= r_shift;
          default: begin
            r_word_out   <= {r_shift, r_lane2, r_lane1, r_lane0};
            r_word_valid <= 1'b1;
          end
        endcase
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end

      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
        r_byte_cnt  <= 2'd0;
      end
`ifdef UART_RX_WORD_PARITY_EN
      if (w_par_fail) r_byte_cnt <= 2'd0;
`endif
    end
  end

`ifdef UART_RX_WORD_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero.
  always_ff @(posedge div_clk) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_fail;
      if (w_par_smp) r_par_bad <= ^{r_shift, w_rx_s};
    end
  end
`endif

  assign word_out    = r_word_out;
  assign word_valid  = r_word_valid;
  assign byte_cnt    = r_byte_cnt;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed plus randomised bench for uart_rx_word_packer against a byte-queue model of the word packer.
`timescale 1ns/1ps
module tb_uart_rx_word_packer;
  localparam int CPB = 16;
  localparam int TOB = 40;
`ifdef UART_RX_WORD_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        div_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        rx      = 1'b1;
  logic [31:0] word_out;
  logic        word_valid;
  logic [1:0]  byte_cnt;
  logic        frame_err, timeout_err, parity_err;

  int checks   = 0;
  int failures = 0;

  always #5 div_clk = ~div_clk;

  uart_rx_word_packer #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .div_clk    (div_clk),
    .reset      (reset),
    .rx         (rx),
    .word_out   (word_out),
    .word_valid (word_valid),
    .byte_cnt   (byte_cnt),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .parity_err (parity_err)
  );

  // Observed activity, sampled on the falling edge.
  int          cyc = 0;
  int          n_ferr = 0, n_terr = 0, n_perr = 0, n_overlap = 0;
  logic [31:0] got_words[$];
  int          valid_cyc[$];

  always @(posedge div_clk) cyc++;

  always @(negedge div_clk) begin
    if (!reset) begin
      if (word_valid) begin
        got_words.push_back(word_out);
        valid_cyc.push_back(cyc);
      end
      if (frame_err)   n_ferr++;
      if (timeout_err) n_terr++;
      if (parity_err)  n_perr++;
      if (word_valid && (frame_err || timeout_err || parity_err)) n_overlap++;
    end
  end

  // Reference model: a queue of accepted bytes forming the current word.
  logic [7:0]  part[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_last = 32'd0;
  int          exp_ferr = 0, exp_terr = 0, exp_perr = 0;
`ifdef UART_RX_WORD_PARITY_EN
  int          par_force = -1;
`endif

  task automatic model_good(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == 4) begin
      exp_last = {part[3], part[2], part[1], part[0]};
      exp_words.push_back(exp_last);
      part.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge div_clk);
    #1;
  endtask

  task automatic sync_check(input string tag);
    chk({tag, ":nvalid"}, got_words.size(), exp_words.size());
    while (got_words.size() > 0 && exp_words.size() > 0)
      chk({tag, ":word"}, got_words.pop_front(), exp_words.pop_front());
    got_words.delete();
    exp_words.delete();
    chk({tag, ":frame_err_cnt"},   n_ferr, exp_ferr);
    chk({tag, ":timeout_err_cnt"}, n_terr, exp_terr);
    chk({tag, ":parity_err_cnt"},  n_perr, exp_perr);
    chk({tag, ":overlap"},         n_overlap, 0);
    chk({tag, ":byte_cnt"},        byte_cnt, part.size());
    chk({tag, ":word_out_hold"},   word_out, exp_last);
  endtask

  task automatic do_abort();
    tick(CPB / 2);
    reset = 1'b1;
    tick(3);
    chk("rst_mid:word_out",    word_out, 0);
    chk("rst_mid:word_valid",  word_valid, 0);
    chk("rst_mid:byte_cnt",    byte_cnt, 0);
    chk("rst_mid:frame_err",   frame_err, 0);
    chk("rst_mid:timeout_err", timeout_err, 0);
    chk("rst_mid:parity_err",  parity_err, 0);
    rx = 1'b1;
    tick(4);
    reset = 1'b0;
    part.delete();
    exp_last = 32'd0;
    tick(2 * CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                            input int abort_at);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_at) begin
        do_abort();
        return;
      end
      tick(CPB);
    end
`ifdef UART_RX_WORD_PARITY_EN
    rx = (par_force < 0) ? ^d : par_force[0];
    tick(CPB);
`endif
    rx = stop_v;
    tick(CPB * stop_len);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, 1, -1);
    model_good(b);
    chk("byte_cnt_after_byte", byte_cnt, part.size());
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_good(w[8*k +: 8]);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rw;
    int          gap;

    // Reset state
    tick(5);
    chk("reset:word_out",    word_out, 0);
    chk("reset:word_valid",  word_valid, 0);
    chk("reset:byte_cnt",    byte_cnt, 0);
    chk("reset:frame_err",   frame_err, 0);
    chk("reset:timeout_err", timeout_err, 0);
    chk("reset:parity_err",  parity_err, 0);
    reset = 1'b0;
    tick(2 * CPB);

    // Single word
    send_word(32'h0000_0001);
    sync_check("t1");

    // Back-to-back words, strobes exactly one word-time apart
    send_word(32'hDEAD_BEEF);
    send_word(32'h0000_0002);
    tick(2);
    if (valid_cyc.size() >= 2)
      chk("t2:valid_spacing", valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2],
          4 * FRAME_BITS * CPB);
    else
      chk("t2:valid_count", valid_cyc.size(), 2);
    sync_check("t2");

    // Inter-byte timeout discards the partial word
    send_good(8'h11);
    send_good(8'h22);
    tick((TOB + 1) * CPB);
    exp_terr++;
    part.delete();
    sync_check("t3_timeout");
    send_word(32'h0000_0002);
    sync_check("t3");

    // Framing error: stop bit held low for three bit periods
    send_good(8'h5A);
    send_frame(8'hAA, 1'b0, 3, -1);
    exp_ferr++;
    part.delete();
    tick(2 * CPB);
    sync_check("t4_ferr");
    send_word(32'h0000_0003);
    sync_check("t4");

    // False start glitch, then reset in the middle of byte 2
    send_good(8'h55);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CPB);
    sync_check("t5_glitch");
    send_frame(8'h66, 1'b1, 1, 4);
    sync_check("t5_reset");
    send_word(32'h0BAD_F00D);
    sync_check("t5");

`ifdef UART_RX_WORD_PARITY_EN
    // Wrong parity drops the byte; correct parity accepts it
    send_good(8'h12);
    par_force = 0;
    send_frame(8'h07, 1'b1, 1, -1);
    exp_perr++;
    part.delete();
    sync_check("t6_bad_parity");
    par_force = 1;
    send_good(8'h07);
    par_force = -1;
    send_good(8'h08);
    send_good(8'h09);
    send_good(8'h0A);
    sync_check("t6");
`endif

    // Random words with random inter-byte gaps kept below the timeout
    for (int w = 0; w < 4; w++) begin
      rw = $urandom;
      for (int k = 0; k < 4; k++) begin
        send_good(rw[8*k +: 8]);
        gap = (w == 0 && k == 0) ? TOB - 2 : int'($urandom_range(0, TOB - 2));
        tick(gap * CPB);
      end
    end
    sync_check("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
